// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse element sequencer.
// Holds the FSM state encoding, the Morse unit durations, and small helpers
// used by the sequencer top level.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_e;

    // Duration counter width: 15 units max (word gap 7 + 8 extra).
    localparam int CNT_W = 4;

    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS   = 7;
    localparam int MAX_ELEMS        = 5;

    // Element counts above the pattern width are treated as a full pattern.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : len;
    endfunction

    // Mark length for one element bit: 1 = dash, 0 = dot.
    function automatic logic [CNT_W-1:0] mark_units(input logic is_dash);
        return is_dash ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);
    endfunction

endpackage

// File: rtl/morse_element_sequencer_if.sv
// Pattern handshake between the character lookup (master) and the
// element sequencer (slave).
interface morse_element_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_len;
    logic [4:0] in_code;
    logic       in_word_end;

    modport master (output in_valid, in_len, in_code, in_word_end, input in_ready);
    modport slave  (input in_valid, in_len, in_code, in_word_end, output in_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Unit-time prescaler: counts 0..UNIT_DIV-1 and flags the last cycle of
// each unit. A synchronous clear restarts the unit so every segment begins
// on a fresh unit boundary.
module morse_unit_timer #(
    parameter int UNIT_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int PW = (UNIT_DIV > 2) ? $clog2(UNIT_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(UNIT_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the end of a unit, or restart on clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/morse_element_sequencer.sv
// Morse element sequencer: turns one dot/dash pattern into a timed key.
// Optional feature macro: MORSE_FARNSWORTH_EN stretches letter and word
// gaps by FARNS_EXTRA units while leaving marks and element spaces alone.
module morse_element_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_DIV    = 5_000_000,
    parameter int FARNS_EXTRA = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    morse_element_sequencer_if.slave        in_if,
    input  logic                            abort,
    output logic                            key_out,
    output logic                            busy,
    output logic                            done
);

    if (UNIT_DIV < 1) begin : g_bad_unit_div
        $error("UNIT_DIV must be at least 1");
    end
    if ((FARNS_EXTRA < 0) || (FARNS_EXTRA > 8)) begin : g_bad_farns_extra
        $error("FARNS_EXTRA must be in 0..8");
    end

`ifdef MORSE_FARNSWORTH_EN
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_GAP_UNITS + FARNS_EXTRA);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_GAP_UNITS + FARNS_EXTRA);
`else
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_GAP_UNITS);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_GAP_UNITS);
`endif

    function automatic logic [CNT_W-1:0] gap_units(input logic word_end);
        return word_end ? WORD_GAP : LETTER_GAP;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [2:0]       idx_q, idx_d, nxt_idx;
    logic             done_q, done_d;
    logic             key_q, key_d;
    logic [2:0]       len_q, len_d;
    logic [4:0]       code_q, code_d;
    logic             word_end_q, word_end_d;
    logic             tick;
    logic             tmr_clr;

    morse_unit_timer #(.UNIT_DIV(UNIT_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clr),
        .tick  (tick)
    );

    // Next-state, segment counter, capture and prescaler-restart logic.
    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        tmr_clr    = 1'b0;
        len_d      = len_q;
        code_d     = code_q;
        word_end_d = word_end_q;
        nxt_idx    = idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (in_if.in_valid) begin
                    len_d      = clamp_len(in_if.in_len);
                    code_d     = in_if.in_code;
                    word_end_d = in_if.in_word_end;
                    idx_d      = '0;
                    if (clamp_len(in_if.in_len) == 3'd0) begin
                        state_d = GAP;
                        dur_d   = gap_units(in_if.in_word_end);
                    end else begin
                        state_d = MARK;
                        dur_d   = mark_units(in_if.in_code[0]);
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    if (dur_q == CNT_W'(1)) begin
                        tmr_clr = 1'b1;
                        if (nxt_idx < len_q) begin
                            state_d = SPACE;
                            dur_d   = CNT_W'(ELEM_GAP_UNITS);
                        end else begin
                            state_d = GAP;
                            dur_d   = gap_units(word_end_q);
                        end
                    end else begin
                        dur_d = dur_q - CNT_W'(1);
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (dur_q == CNT_W'(1)) begin
                        tmr_clr = 1'b1;
                        idx_d   = nxt_idx;
                        state_d = MARK;
                        dur_d   = mark_units(code_q[nxt_idx]);
                    end else begin
                        dur_d = dur_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (dur_q == CNT_W'(1)) begin
                        tmr_clr = 1'b1;
                        state_d = IDLE;
                        dur_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        dur_d = dur_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a handshake in the same cycle.
        if (abort) begin
            state_d    = IDLE;
            dur_d      = '0;
            idx_d      = '0;
            done_d     = 1'b0;
            tmr_clr    = 1'b1;
            len_d      = len_q;
            code_d     = code_q;
            word_end_d = word_end_q;
        end

        key_d = (state_d == MARK);
    end

    // Control registers: state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dur_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            key_q   <= key_d;
        end
    end

    // Captured pattern; only read once a handshake has loaded it.
    always_ff @(posedge clk) begin
        len_q      <= len_d;
        code_q     <= code_d;
        word_end_q <= word_end_d;
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign key_out        = key_q;
    assign done           = done_q;

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Directed bench for morse_element_sequencer: three instances (UNIT_DIV 4,
// 1 and 2), expected key/done/ready per cycle queued at each handshake from
// a unit-level Morse timing model and popped every cycle.
module tb_morse_element_sequencer;

`ifdef MORSE_FARNSWORTH_EN
    localparam int FARNS_EFF = 2;
`else
    localparam int FARNS_EFF = 0;
`endif

    typedef struct {
        logic key;
        logic done;
        logic rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] valid_r;
    logic [2:0] we_r;
    logic [2:0] abort_r;
    logic [2:0] len_r  [3];
    logic [4:0] code_r [3];
    logic [2:0] key_w, done_w, busy_w, ready_w;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        morse_element_sequencer_if bus ();
        assign bus.in_valid    = valid_r[g];
        assign bus.in_len      = len_r[g];
        assign bus.in_code     = code_r[g];
        assign bus.in_word_end = we_r[g];
        assign ready_w[g]      = bus.in_ready;

        morse_element_sequencer #(
            .UNIT_DIV    ((g == 0) ? 4 : ((g == 1) ? 1 : 2)),
            .FARNS_EXTRA ((g == 1) ? 2 : 0)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .in_if   (bus),
            .abort   (abort_r[g]),
            .key_out (key_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );
    end

    function automatic int ud_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic k, input logic d, input logic r);
        exp_t e;
        e.key = k; e.done = d; e.rdy = r;
        exp_q.push_back(e);
    endtask

    // Unit-level model of one character: marks, element spaces, closing gap.
    task automatic build_exp(input int k, input logic [2:0] len,
                             input logic [4:0] code, input logic we);
        int n, ud, units;
        ud = ud_of(k);
        n  = (len > 3'd5) ? 5 : int'(len);
        for (int i = 0; i < n; i++) begin
            units = code[i] ? 3 : 1;
            repeat (units * ud) push(1'b1, 1'b0, 1'b0);
            if (i < n - 1) repeat (ud) push(1'b0, 1'b0, 1'b0);
        end
        units = (we ? 7 : 3) + ((k == 1) ? FARNS_EFF : 0);
        repeat (units * ud) push(1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1);
    endtask

    // Offer a pattern in the current cycle; returns in the following cycle.
    task automatic send(input int k, input logic [2:0] len,
                        input logic [4:0] code, input logic we);
        chk("ready_before_send", ready_w[k], 1'b1);
        valid_r[k] = 1'b1;
        len_r[k]   = len;
        code_r[k]  = code;
        we_r[k]    = we;
        build_exp(k, len, code, we);
        next_cycle();
        valid_r[k] = 1'b0;
    endtask

    task automatic check_one(input int k);
        exp_t e;
        e = exp_q.pop_front();
        chk("key_out", key_w[k], e.key);
        chk("done", done_w[k], e.done);
        chk("in_ready", ready_w[k], e.rdy);
        chk("busy", busy_w[k], ~e.rdy);
    endtask

    // Compare every queued cycle; ends in the cycle carrying done.
    task automatic drain(input int k);
        while (exp_q.size() > 0) begin
            check_one(k);
            if (exp_q.size() > 0) next_cycle();
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        chk({tag, "_key"}, key_w[k], 1'b0);
        chk({tag, "_ready"}, ready_w[k], 1'b1);
        chk({tag, "_busy"}, busy_w[k], 1'b0);
        chk({tag, "_done"}, done_w[k], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_r = '0; we_r = '0; abort_r = '0;
        for (int i = 0; i < 3; i++) begin
            len_r[i] = '0;
            code_r[i] = '0;
        end

        repeat (3) next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) check_idle(k, "reset_state");

        // "A" at UNIT_DIV=4: dot, space, dash, letter gap, done at cycle 33.
        send(0, 3'd2, 5'b00010, 1'b0);
        drain(0);

        // "A" again with a second pattern offered throughout the busy time.
        send(0, 3'd2, 5'b00010, 1'b0);
        valid_r[0] = 1'b1; len_r[0] = 3'd1; code_r[0] = 5'b00001; we_r[0] = 1'b0;
        drain(0);
        valid_r[0] = 1'b0;
        next_cycle();
        check_idle(0, "held_valid_ignored");

        // Abort in cycle 6 of "A": idle from cycle 7, no done afterwards.
        send(0, 3'd2, 5'b00010, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            check_one(0);
            if (c < 6) next_cycle();
        end
        abort_r[0] = 1'b1;
        next_cycle();
        abort_r[0] = 1'b0;
        exp_q.delete();
        check_idle(0, "after_abort");
        repeat (40) begin
            next_cycle();
            chk("abort_no_done", done_w[0], 1'b0);
            chk("abort_key_low", key_w[0], 1'b0);
        end

        // Reset in the middle of the dash of "A", then a clean "A".
        send(0, 3'd2, 5'b00010, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            check_one(0);
            if (c < 12) next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        exp_q.delete();
        check_idle(0, "after_reset");
        send(0, 3'd2, 5'b00010, 1'b0);
        drain(0);

        // UNIT_DIV=1: "E" with word gap, then "T" accepted in the done cycle.
        send(1, 3'd1, 5'b00000, 1'b1);
        drain(1);
        send(1, 3'd1, 5'b00001, 1'b0);
        drain(1);

        // UNIT_DIV=2: space character, then len 7 clamped to five dashes.
        send(2, 3'd0, 5'b00000, 1'b1);
        drain(2);
        send(2, 3'd7, 5'b11111, 1'b1);
        drain(2);

        next_cycle();
        for (int k = 0; k < 3; k++) check_idle(k, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
